// File: rtl/osd_uart_tx_sched_pkg.sv
// Shared types and constants for the OSD UART transmit scheduler.
// Pure definitions; no logic and no latency.
// No flow control here; consumers apply the handshakes.
package osd_uart_tx_sched_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SEND  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Requester identities, also the encoding reported on grant_id
  localparam logic [1:0] REQ_KBD = 2'd0;
  localparam logic [1:0] REQ_EVT = 2'd1;
  localparam logic [1:0] REQ_PDL = 2'd2;

  // Default frame header / command bytes
  localparam logic [7:0] EVT_HDR_DEF = 8'hFE;
  localparam logic [7:0] PDL_CMD_DEF = 8'hFD;

  // Disk status-event byte layout: {powerOn, drive12, dskRW, phaseChange, 2'b00, phases}
  localparam int STS_POWER_ON_BIT  = 7;
  localparam int STS_DRIVE12_BIT   = 6;
  localparam int STS_DSK_RW_BIT    = 5;
  localparam int STS_PHASE_CHG_BIT = 4;
  localparam int STS_PHASES_MSB    = 1;
  localparam int STS_PHASES_LSB    = 0;

  // Keystrokes travel as 7-bit ASCII with the top bit forced low
  function automatic logic [7:0] kbd_byte(input logic [7:0] d);
    return {1'b0, d[6:0]};
  endfunction

  // Next requester id in the 0 -> 1 -> 2 -> 0 rotation
  function automatic logic [1:0] next_req(input logic [1:0] id);
    return (id >= REQ_PDL) ? REQ_KBD : id + 2'd1;
  endfunction

endpackage

// File: rtl/osd_uart_tx_sched_if.sv
// Requester and UART-sender signals of the transmit scheduler.
// Wires only; no latency.
// valid is held by requesters until ready pulses; tx_idle paces the sender side.
interface osd_uart_tx_sched_if;
  logic       kbd_valid;
  logic [7:0] kbd_data;
  logic       kbd_ready;
  logic       evt_valid;
  logic [7:0] evt_data;
  logic       evt_ready;
  logic       pdl_valid;
  logic       pdl_ready;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_idle;

  // Requesters plus UART sender side
  modport master (
    output kbd_valid, kbd_data, evt_valid, evt_data, pdl_valid, tx_idle,
    input  kbd_ready, evt_ready, pdl_ready, tx_data, tx_en
  );

  // Scheduler side
  modport slave (
    input  kbd_valid, kbd_data, evt_valid, evt_data, pdl_valid, tx_idle,
    output kbd_ready, evt_ready, pdl_ready, tx_data, tx_en
  );
endinterface

// File: rtl/osd_uart_tx_sched_rr_arb3.sv
// 3-way round-robin arbiter: search starts one past the last grant.
// Combinational, zero latency.
// No backpressure; the caller decides when a grant is taken.
module rr_arb3
  import osd_uart_tx_sched_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last_id,
  output logic       gnt_vld,
  output logic [1:0] gnt_id
);

  logic [1:0] c0, c1, c2;

  // Rotate the priority order and pick the first active requester
  always_comb begin
    c0      = next_req(last_id);
    c1      = next_req(c0);
    c2      = next_req(c1);
    gnt_vld = 1'b1;
    gnt_id  = c0;
    if (req[c0]) begin
      gnt_id = c0;
    end else if (req[c1]) begin
      gnt_id = c1;
    end else if (req[c2]) begin
      gnt_id = c2;
    end else begin
      gnt_vld = 1'b0;
      gnt_id  = last_id;
    end
  end

endmodule

// File: rtl/osd_uart_tx_sched.sv
// Schedules keystroke, disk-event and paddle-poll frames onto one UART sender.
// valid at edge k -> ready/LOAD in k+1 -> tx_en from k+2; one frame per IDLE visit.
// Requesters hold valid until ready; each byte waits for the sender's tx_idle handshake, frame dropped on timeout.
module osd_uart_tx_sched
  import osd_uart_tx_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter logic [7:0]  EVT_HDR     = EVT_HDR_DEF,
  parameter logic [7:0]  PDL_CMD     = PDL_CMD_DEF
) (
  input  logic                  clk,
  input  logic                  RstN,
  osd_uart_tx_sched_if.slave    bus,
  output logic                  busy,
  output logic [1:0]            grant_id,
  input  logic                  err_clr,
  output logic                  timeout_err
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  state_e        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [7:0]    b0_q, b0_d;
  logic [7:0]    b1_q, b1_d;
  logic          two_q, two_d;     // frame carries a second byte
  logic          idx_q, idx_d;     // byte currently on the wire
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_en_q, tx_en_d;
  logic          kbd_rdy_q, kbd_rdy_d;
  logic          evt_rdy_q, evt_rdy_d;
  logic          pdl_rdy_q, pdl_rdy_d;
  logic          err_q, err_d;
  logic [CW-1:0] tmo_q, tmo_d;

  logic          arb_vld;
  logic [1:0]    arb_id;

  rr_arb3 u_arb (
    .req     ({bus.pdl_valid, bus.evt_valid, bus.kbd_valid}),
    .last_id (grant_q),
    .gnt_vld (arb_vld),
    .gnt_id  (arb_id)
  );

  // Next-state and output computation for the frame scheduler
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    b0_d      = b0_q;
    b1_d      = b1_q;
    two_d     = two_q;
    idx_d     = idx_q;
    tx_data_d = tx_data_q;
    tx_en_d   = tx_en_q;
    kbd_rdy_d = 1'b0;
    evt_rdy_d = 1'b0;
    pdl_rdy_d = 1'b0;
    tmo_d     = tmo_q;
    // A clear loses to a timeout raised in the same cycle (set below)
    err_d     = err_clr ? 1'b0 : err_q;

    case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          grant_d = arb_id;
          idx_d   = 1'b0;
          tmo_d   = '0;
          state_d = ST_LOAD;
          case (arb_id)
            REQ_KBD: begin
              b0_d      = kbd_byte(bus.kbd_data);
              two_d     = 1'b0;
              kbd_rdy_d = 1'b1;
            end
            REQ_EVT: begin
              b0_d      = EVT_HDR;
              b1_d      = bus.evt_data;
              two_d     = 1'b1;
              evt_rdy_d = 1'b1;
            end
            default: begin
              b0_d      = PDL_CMD;
              two_d     = 1'b0;
              pdl_rdy_d = 1'b1;
            end
          endcase
        end
      end
      ST_LOAD: begin
        tx_data_d = idx_q ? b1_q : b0_q;
        tx_en_d   = 1'b1;
        tmo_d     = '0;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (!bus.tx_idle) begin
          tx_en_d = 1'b0;
          state_d = ST_DRAIN;
        end else if (tmo_q == TMO_LAST) begin
          // Sender never started: drop the whole frame
          tx_en_d = 1'b0;
          err_d   = 1'b1;
          tmo_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + CW'(1);
        end
      end
      ST_DRAIN: begin
        if (bus.tx_idle) begin
          if (two_q && !idx_q) begin
            idx_d   = 1'b1;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_en_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any frame in flight
  always_ff @(posedge clk or negedge RstN) begin
    if (!RstN) begin
      state_q   <= ST_IDLE;
      grant_q   <= REQ_PDL;
      b0_q      <= 8'h00;
      b1_q      <= 8'h00;
      two_q     <= 1'b0;
      idx_q     <= 1'b0;
      tx_data_q <= 8'h00;
      tx_en_q   <= 1'b0;
      kbd_rdy_q <= 1'b0;
      evt_rdy_q <= 1'b0;
      pdl_rdy_q <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      b0_q      <= b0_d;
      b1_q      <= b1_d;
      two_q     <= two_d;
      idx_q     <= idx_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      kbd_rdy_q <= kbd_rdy_d;
      evt_rdy_q <= evt_rdy_d;
      pdl_rdy_q <= pdl_rdy_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  end

  assign bus.kbd_ready = kbd_rdy_q;
  assign bus.evt_ready = evt_rdy_q;
  assign bus.pdl_ready = pdl_rdy_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_en     = tx_en_q;
  assign busy          = (state_q != ST_IDLE);
  assign grant_id      = grant_q;
  assign timeout_err   = err_q;

endmodule

// File: tb/tb_osd_uart_tx_sched.sv
// Directed bench for osd_uart_tx_sched with a simple UART sender model.
// All driving and sampling happens on the falling clock edge.
// Requesters withdraw valid as soon as their ready pulse is seen.
module tb_osd_uart_tx_sched;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       RstN;
  logic       busy;
  logic [1:0] grant_id;
  logic       err_clr;
  logic       timeout_err;

  osd_uart_tx_sched_if bus();

  osd_uart_tx_sched #(.TIMEOUT_CYC(T)) dut (
    .clk         (clk),
    .RstN        (RstN),
    .bus         (bus.slave),
    .busy        (busy),
    .grant_id    (grant_id),
    .err_clr     (err_clr),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] sent[$];
  logic [1:0] glog[$];
  bit         uart_auto;
  int         en_cnt;
  int         bsy_cnt;
  int         en_rise;
  logic       en_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: requesters react to ready, sender model accepts a byte
  // after tx_en has been high two cycles, then stays busy for 3 cycles.
  task automatic tick;
    @(negedge clk);
    if (bus.kbd_ready) begin glog.push_back(2'd0); bus.kbd_valid = 1'b0; end
    if (bus.evt_ready) begin glog.push_back(2'd1); bus.evt_valid = 1'b0; end
    if (bus.pdl_ready) begin glog.push_back(2'd2); bus.pdl_valid = 1'b0; end
    if (bus.tx_en && !en_prev) en_rise++;
    en_prev = bus.tx_en;
    if (uart_auto) begin
      if (bus.tx_en && bus.tx_idle) begin
        en_cnt++;
        if (en_cnt == 2) begin
          sent.push_back(bus.tx_data);
          bus.tx_idle = 1'b0;
          bsy_cnt     = 3;
          en_cnt      = 0;
        end
      end else if (!bus.tx_idle) begin
        bsy_cnt--;
        if (bsy_cnt == 0) bus.tx_idle = 1'b1;
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 300) begin tick(); n++; end
    chk(tag, 32'(busy), 0);
  endtask

  task automatic wait_grants(input string tag, input int want);
    int n = 0;
    while (glog.size() < want && n < 1000) begin tick(); n++; end
    chk(tag, glog.size(), want);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sb, gb, r0, hi, k;
    RstN          = 1'b0;
    err_clr       = 1'b0;
    bus.kbd_valid = 1'b0;
    bus.kbd_data  = 8'h00;
    bus.evt_valid = 1'b0;
    bus.evt_data  = 8'h00;
    bus.pdl_valid = 1'b0;
    bus.tx_idle   = 1'b1;
    uart_auto     = 1'b1;
    en_cnt = 0; bsy_cnt = 0; en_rise = 0; en_prev = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_busy",  32'(busy), 0);
    chk("rst_tx_en", 32'(bus.tx_en), 0);
    chk("rst_tx_data", 32'(bus.tx_data), 0);
    chk("rst_grant", 32'(grant_id), 2);
    chk("rst_err",   32'(timeout_err), 0);
    chk("rst_ready", 32'({bus.kbd_ready, bus.evt_ready, bus.pdl_ready}), 0);
    RstN = 1'b1;
    tick();

    // Single keystroke: 8'hC1 goes out as 8'h41
    bus.kbd_valid = 1'b1; bus.kbd_data = 8'hC1;
    tick();
    chk("kbd_ready_k1", 32'(bus.kbd_ready), 1);
    chk("kbd_busy_k1",  32'(busy), 1);
    chk("kbd_grant",    32'(grant_id), 0);
    chk("kbd_tx_en_k1", 32'(bus.tx_en), 0);
    tick();
    chk("kbd_ready_k2", 32'(bus.kbd_ready), 0);
    chk("kbd_tx_en_k2", 32'(bus.tx_en), 1);
    chk("kbd_tx_data",  32'(bus.tx_data), 'h41);
    wait_idle("kbd_done");
    chk("kbd_nbytes", sent.size(), 1);
    chk("kbd_byte",   32'(sent[0]), 'h41);

    // Disk event: header then status byte, busy across both
    r0 = en_rise;
    bus.evt_valid = 1'b1; bus.evt_data = 8'h83;
    tick();
    chk("evt_ready", 32'(bus.evt_ready), 1);
    chk("evt_grant", 32'(grant_id), 1);
    wait_idle("evt_done");
    chk("evt_nbytes", sent.size(), 3);
    chk("evt_hdr",    32'(sent[1]), 'hFE);
    chk("evt_sts",    32'(sent[2]), 'h83);
    chk("evt_en_pulses", 32'(en_rise - r0), 2);

    // Paddle poll alone
    bus.pdl_valid = 1'b1;
    tick();
    chk("pdl_ready", 32'(bus.pdl_ready), 1);
    chk("pdl_grant", 32'(grant_id), 2);
    wait_idle("pdl_done");
    chk("pdl_byte", 32'(sent[3]), 'hFD);

    // All three at once, two rounds
    for (int rnd = 0; rnd < 2; rnd++) begin
      gb = glog.size();
      sb = sent.size();
      bus.kbd_valid = 1'b1; bus.kbd_data = (rnd == 0) ? 8'h35 : 8'hE6;
      bus.evt_valid = 1'b1; bus.evt_data = 8'h42;
      bus.pdl_valid = 1'b1;
      wait_grants("rr_grants", gb + 3);
      wait_idle("rr_done");
      chk("rr_g0", 32'(glog[gb]),     0);
      chk("rr_g1", 32'(glog[gb + 1]), 1);
      chk("rr_g2", 32'(glog[gb + 2]), 2);
      chk("rr_nbytes", sent.size(), sb + 4);
      chk("rr_kbd", 32'(sent[sb]), (rnd == 0) ? 'h35 : 'h66);
      chk("rr_pdl", 32'(sent[sb + 3]), 'hFD);
    end

    // Timeout: sender never leaves idle; err_clr in the abort cycle loses
    uart_auto   = 1'b0;
    bus.tx_idle = 1'b1;
    sb = sent.size();
    bus.pdl_valid = 1'b1;
    hi = 0;
    k  = 0;
    while (k < 200) begin
      tick();
      k++;
      if (bus.tx_en) begin
        hi++;
        if (hi == T) err_clr = 1'b1;
      end else if (hi > 0) begin
        break;
      end
    end
    err_clr = 1'b0;
    chk("tmo_en_cycles", 32'(hi), T);
    chk("tmo_err_set",   32'(timeout_err), 1);
    chk("tmo_busy",      32'(busy), 0);
    chk("tmo_tx_en",     32'(bus.tx_en), 0);
    chk("tmo_no_bytes",  sent.size(), sb);
    tick();
    chk("tmo_err_sticky", 32'(timeout_err), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("tmo_err_clr", 32'(timeout_err), 0);

    // Reset during the second event byte's drain; waiting kbd served after
    uart_auto = 1'b1;
    sb = sent.size();
    bus.evt_valid = 1'b1; bus.evt_data = 8'h0A;
    tick();
    chk("rst_evt_ready", 32'(bus.evt_ready), 1);
    gb = glog.size();
    bus.kbd_valid = 1'b1; bus.kbd_data = 8'h5A;
    k = 0;
    while (sent.size() < sb + 2 && k < 200) begin tick(); k++; end
    chk("rst_evt_bytes", sent.size(), sb + 2);
    chk("rst_evt_sts",   32'(sent[sb + 1]), 'h0A);
    chk("rst_kbd_held",  glog.size(), gb);
    tick();
    chk("drain_tx_en", 32'(bus.tx_en), 0);
    chk("drain_busy",  32'(busy), 1);
    RstN = 1'b0;
    #1;
    chk("mid_rst_busy",  32'(busy), 0);
    chk("mid_rst_tx_en", 32'(bus.tx_en), 0);
    chk("mid_rst_grant", 32'(grant_id), 2);
    tick();
    tick();
    RstN = 1'b1;
    wait_grants("post_rst_grant_cnt", gb + 1);
    chk("post_rst_grant", 32'(glog[gb]), 0);
    wait_idle("post_rst_done");
    chk("post_rst_nbytes", sent.size(), sb + 3);
    chk("post_rst_byte",   32'(sent[sb + 2]), 'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/osd_uart_tx_sched.md
OSD_UART_TX_SCHED -- requirements
Module: osd_uart_tx_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1024: max clk cycles tx_en may stay high without tx_idle going low.
REQ-002 SHALL have parameter EVT_HDR, default 8'hFE: header byte of a disk-event frame.
REQ-003 SHALL have parameter PDL_CMD, default 8'hFD: paddle-poll command byte.
REQ-004 clk  in  1  system clock, same domain as the UART sender and receiver.
REQ-005 RstN  in  1  reset, asynchronous, active-low.
REQ-006 kbd_valid  in  1  OSD keystroke request; held until kbd_ready.
REQ-007 kbd_data  in  8  keystroke ASCII.
REQ-008 kbd_ready  out  1  one-cycle pulse: keystroke accepted.
REQ-009 evt_valid  in  1  disk status-event request; held until evt_ready.
REQ-010 evt_data  in  8  status byte: {powerOn, drive12, dskRW, phaseChange, 2'b00, phases}.
REQ-011 evt_ready  out  1  one-cycle pulse: event accepted.
REQ-012 pdl_valid  in  1  paddle-poll request; held until pdl_ready.
REQ-013 pdl_ready  out  1  one-cycle pulse: poll accepted.
REQ-014 tx_data  out  8  byte to UART sender uart_din.
REQ-015 tx_en  out  1  UART sender start (uart_en).
REQ-016 tx_idle  in  1  UART sender idle flag.
REQ-017 busy  out  1  high whenever state is not IDLE.
REQ-018 grant_id  out  2  last granted requester: 0 kbd, 1 evt, 2 pdl.
REQ-019 err_clr  in  1  clears timeout_err.
REQ-020 timeout_err  out  1  sticky: a frame was dropped on timeout.

Function
REQ-021 Frames: kbd = 1 byte {1'b0, kbd_data[6:0]}; evt = 2 bytes EVT_HDR then evt_data; pdl = 1 byte PDL_CMD.
REQ-022 States: IDLE, LOAD, SEND, DRAIN; registered, one-hot or binary free.
REQ-023 IDLE: at an edge with any valid high, capture the winner's frame and byte count, set grant_id, pulse its ready for exactly the next cycle, go LOAD.
REQ-024 Arbitration: round-robin, search order starts at (grant_id+1) mod 3; after reset grant_id = 2 so kbd wins first.
REQ-025 Simultaneous requests: exactly one granted per IDLE visit; losers keep valid and are served in later visits.
REQ-026 LOAD: drive tx_data with the current byte, go SEND; tx_data stays stable until next LOAD.
REQ-027 SEND: tx_en = 1; when tx_idle = 0 observed, tx_en drops on the following edge, go DRAIN.
REQ-028 DRAIN: wait for tx_idle = 1; then, if bytes remain, go LOAD with the next byte, else go IDLE.
REQ-029 Latency: valid sampled at edge k -> ready high and state LOAD in cycle k+1 -> tx_en high from cycle k+2.
REQ-030 Timeout: counter runs in SEND; reaching TIMEOUT_CYC-1 without tx_idle = 0 aborts the whole frame, sets timeout_err, tx_en = 0, go IDLE.
REQ-031 err_clr and a new timeout in the same cycle: timeout wins (timeout_err = 1).
REQ-032 A valid dropped before its ready is a withdrawn request; no ready, no bytes sent.
REQ-033 Requests arriving while busy are not accepted until the next IDLE cycle.

Reset
REQ-034 RstN low: state IDLE, tx_en 0, tx_data 8'h00, all ready 0, busy 0, grant_id 2'd2, timeout_err 0, counters 0.
REQ-035 Reset mid-frame aborts it immediately; no partial byte resumes after release.

Structure
REQ-036 Shared package SHALL hold the state enum, requester ID constants (REQ_KBD/EVT/PDL), EVT_HDR and PDL_CMD defaults, and the status-byte bit positions.
REQ-037 A single sub-module rr_arb3 (3-way round-robin, combinational grant from valid and last grant) is natural; everything else stays in osd_uart_tx_sched.

Verification
REQ-038 kbd_valid, kbd_data 8'hC1; tx_idle model drops 2 cycles after tx_en -> kbd_ready at k+1, tx_en at k+2, tx_data 8'h41, one byte.
REQ-039 evt_valid, evt_data 8'h83 -> bytes 8'hFE then 8'h83, tx_en pulsed twice, busy high throughout, grant_id 1.
REQ-040 All three valid at once, held -> grant order kbd, evt, pdl; second round with all valid -> kbd, evt, pdl again.
REQ-041 tx_idle held 1 forever after pdl request -> tx_en high TIMEOUT_CYC cycles, timeout_err 1, IDLE; err_clr -> 0.
REQ-042 RstN low during second evt byte in DRAIN -> tx_en 0, state IDLE, grant_id 2; after release a waiting kbd request is served first.
